mem_ctrl: RTL and testbench

- Memory access controller between the processor core and the 16x8 data RAM.
- Accepts single read/write requests from the core over a valid/ready handshake and sequences the RAM's `we`/`rd` strobes.
- Accounts for the RAM's one-cycle registered read latency and returns a response over a valid/ready handshake.
- Also provides a hardware clear sequence that writes CLEAR_VALUE to every RAM word.

---
 rtl/mem_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory access controller between the core and a small synchronous data RAM.
// Serialises single read/write requests onto the RAM strobes, absorbs the
// RAM's one-cycle registered read latency, returns a held response, and can
// sweep CLEAR_VALUE into every RAM word on demand.
module mem_ctrl #(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              clr_start,
    output logic              clr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_dataIn,
    output logic              ram_we,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_dataOut
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RDW  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;
    localparam logic [2:0] S_CLR  = 3'd5;

    // Last word of the clear sweep; the counter wraps back to zero from here.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_clr_done;

    logic              w_idle;
    logic              w_in_clr;

    assign w_idle   = (r_state == S_IDLE);
    assign w_in_clr = (r_state == S_CLR);

    // Handshake and status decode; a clear request blocks acceptance in the same cycle.
    assign req_ready  = w_idle & ~clr_start;
    assign busy       = ~w_idle;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign clr_done   = r_clr_done;

    // RAM strobes are pure state decode, so they drop as soon as reset hits.
    assign ram_we      = (r_state == S_WR) | w_in_clr;
    assign ram_rd      = (r_state == S_RD);
    assign ram_address = w_in_clr ? r_clr_cnt : r_addr_q;
    assign ram_dataIn  = w_in_clr ? CLEAR_VALUE : r_wdata_q;

    // Sequencer: request capture, read wait, response hold and clear sweep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_clr_cnt    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_clr_done   <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_clr_cnt <= '0;
                        r_state   <= S_CLR;
                    end else if (req_valid) begin
                        r_addr_q  <= req_addr;
                        r_wdata_q <= req_wdata;
                        r_state   <= req_write ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    // RAM registers dataOut at this edge; it is usable next cycle.
                    r_state <= S_RDW;
                end
                S_RDW: begin
                    r_resp_rdata <= ram_dataOut;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_WR: begin
                    // Writes echo the stored data back as their response.
                    r_resp_rdata <= r_wdata_q;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_CLR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_clr_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 16x8 registered-read RAM.
module tb_mem_ctrl;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic       clr_start;
    logic       clr_done;
    logic       busy;
    logic [3:0] ram_address;
    logic [7:0] ram_dataIn;
    logic       ram_we;
    logic       ram_rd;
    logic [7:0] ram_dataOut = 8'h00;

    logic [7:0] mem [16];
    logic       mem_init = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    mem_ctrl #(.ADDR_W(4), .DATA_W(8), .CLEAR_VALUE(8'h00)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .clr_start   (clr_start),
        .clr_done    (clr_done),
        .busy        (busy),
        .ram_address (ram_address),
        .ram_dataIn  (ram_dataIn),
        .ram_we      (ram_we),
        .ram_rd      (ram_rd),
        .ram_dataOut (ram_dataOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: word i starts at 0x40+i, write on we, registered read on rd.
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h40 + 8'(i);
            mem_init <= 1'b1;
        end else begin
            if (ram_we) mem[ram_address] <= ram_dataIn;
            if (ram_rd) ram_dataOut <= mem[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Strobes must never overlap.
    always @(negedge clock) begin
        if (reset) chk("we_rd_excl", 32'(ram_we & ram_rd), 32'd0);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue one request, wait for its response, check data and latency.
    task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] exp, input string tag, output int t_acc);
        int n;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        tick;
        t_acc     = cyc;
        req_valid = 1'b0;
        req_addr  = ~a;
        req_wdata = ~d;
        n = 0;
        while (!resp_valid && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
        chk({tag, "_lat"}, 32'(n), w ? 32'd1 : 32'd2);
        chk({tag, "_data"}, 32'(resp_rdata), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, t4;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 4'h0;
        req_wdata  = 8'h00;
        resp_ready = 1'b1;
        clr_start  = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_rd", 32'(ram_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        tick;
        tick;
        reset = 1'b1;

        // Write 0xA5 to address 3, changing inputs after accept.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
        #1;
        chk("wr_req_ready", 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0; req_addr = 4'd9; req_wdata = 8'h3C;
        #1;
        chk("wr_we", 32'(ram_we), 32'd1);
        chk("wr_addr", 32'(ram_address), 32'd3);
        chk("wr_din", 32'(ram_dataIn), 32'hA5);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_vld_early", 32'(resp_valid), 32'd0);
        chk("wr_req_ready_busy", 32'(req_ready), 32'd0);
        tick;
        chk("wr_we_off", 32'(ram_we), 32'd0);
        chk("wr_resp_vld", 32'(resp_valid), 32'd1);
        chk("wr_resp_data", 32'(resp_rdata), 32'hA5);
        tick;
        chk("wr_idle", 32'(busy), 32'd0);
        chk("wr_vld_off", 32'(resp_valid), 32'd0);

        // Read address 3 back.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
        #1;
        tick;
        req_valid = 1'b0; req_addr = 4'd0;
        #1;
        chk("rd_rd", 32'(ram_rd), 32'd1);
        chk("rd_we", 32'(ram_we), 32'd0);
        chk("rd_addr", 32'(ram_address), 32'd3);
        tick;
        chk("rdw_rd_off", 32'(ram_rd), 32'd0);
        chk("rdw_vld", 32'(resp_valid), 32'd0);
        tick;
        chk("rd_resp_vld", 32'(resp_valid), 32'd1);
        chk("rd_resp_data", 32'(resp_rdata), 32'hA5);
        tick;
        chk("rd_idle", 32'(busy), 32'd0);

        // Read address 7 with the response held off for 5 cycles.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7;
        #1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        chk("hold_vld0", 32'(resp_valid), 32'd1);
        chk("hold_data0", 32'(resp_rdata), 32'h47);
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_addr = 4'd1;
            tick;
            chk("hold_vld", 32'(resp_valid), 32'd1);
            chk("hold_data", 32'(resp_rdata), 32'h47);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick;
        chk("hold_idle", 32'(busy), 32'd0);
        chk("hold_vld_off", 32'(resp_valid), 32'd0);
        chk("hold_req_ready_idle", 32'(req_ready), 32'd1);

        // Back-to-back requests with resp_ready tied high.
        issue(1'b1, 4'd0,  8'h11, 8'h11, "b2b_w0",  t0);
        issue(1'b1, 4'd15, 8'h22, 8'h22, "b2b_w15", t1);
        issue(1'b0, 4'd15, 8'h00, 8'h22, "b2b_r15", t2);
        issue(1'b0, 4'd0,  8'h00, 8'h11, "b2b_r0",  t3);
        issue(1'b1, 4'd5,  8'h33, 8'h33, "b2b_w5",  t4);
        chk("space_w_w", 32'(t1 - t0), 32'd3);
        chk("space_w_r", 32'(t2 - t1), 32'd3);
        chk("space_r_r", 32'(t3 - t2), 32'd4);
        chk("space_r_w", 32'(t4 - t3), 32'd4);
        tick;

        // Full clear sweep.
        clr_start = 1'b1;
        #1;
        chk("clr_req_ready", 32'(req_ready), 32'd0);
        tick;
        clr_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("clr_we", 32'(ram_we), 32'd1);
            chk("clr_rd", 32'(ram_rd), 32'd0);
            chk("clr_addr", 32'(ram_address), 32'(i));
            chk("clr_din", 32'(ram_dataIn), 32'd0);
            chk("clr_done_early", 32'(clr_done), 32'd0);
            tick;
        end
        chk("clr_done_pulse", 32'(clr_done), 32'd1);
        chk("clr_we_off", 32'(ram_we), 32'd0);
        chk("clr_idle", 32'(busy), 32'd0);
        tick;
        chk("clr_done_off", 32'(clr_done), 32'd0);
        issue(1'b0, 4'd9, 8'h00, 8'h00, "clr_rd9", t0);
        tick;

        // Clear and read requested together: clear wins, read follows it.
        clr_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd2;
        #1;
        chk("pri_req_ready", 32'(req_ready), 32'd0);
        tick;
        clr_start = 1'b0;
        #1;
        chk("pri_in_clr_we", 32'(ram_we), 32'd1);
        chk("pri_in_clr_rd", 32'(ram_rd), 32'd0);
        for (int i = 0; i < 16; i++) tick;
        chk("pri_clr_done", 32'(clr_done), 32'd1);
        chk("pri_req_ready_idle", 32'(req_ready), 32'd1);
        chk("pri_rd_not_yet", 32'(ram_rd), 32'd0);
        tick;
        req_valid = 1'b0;
        #1;
        chk("pri_rd", 32'(ram_rd), 32'd1);
        chk("pri_rd_addr", 32'(ram_address), 32'd2);
        tick;
        tick;
        chk("pri_resp_vld", 32'(resp_valid), 32'd1);
        chk("pri_resp_data", 32'(resp_rdata), 32'd0);
        tick;

        // Reset in the middle of a clear.
        clr_start = 1'b1;
        tick;
        clr_start = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        chk("abort_addr6", 32'(ram_address), 32'd6);
        chk("abort_we_pre", 32'(ram_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_we", 32'(ram_we), 32'd0);
        chk("abort_rd", 32'(ram_rd), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(ram_address), 32'd0);
        chk("abort_vld", 32'(resp_valid), 32'd0);
        chk("abort_rdata", 32'(resp_rdata), 32'd0);
        chk("abort_clr_done", 32'(clr_done), 32'd0);
        tick;
        tick;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("abort_no_done", 32'(clr_done), 32'd0);
        end
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
